hack_state_unit: RTL and testbench
==================================

# hack_state_unit

Sequential state-holding stage of the Hack CPU. It sits directly downstream of the A-input 16-bit multiplexer, which selects between instruction and ALU output, and consumes that mux's output. The block owns the A, D and PC registers, the instruction register, jump evaluation, and a fetch/execute/write FSM. The FSM handshakes with instruction ROM and data RAM so that memories with variable latency can be used.

## Interface
Parameters:
- PC_W, 15, program-counter and RAM-address width (Hack fixed; wraps at 2^PC_W)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- instr  in  16  instruction word from ROM
- instr_valid  in  1  ROM data valid; sampled only in FETCH
- a_mux_out  in  16  output of upstream A-input mux (sel = ir[15]); load value for A
- alu_out  in  16  ALU result for current ir
- zr  in  1  ALU zero flag
- ng  in  1  ALU negative flag
- mem_ack  in  1  RAM write accepted; sampled only in WRITE
- fetch_req  out  1  high in FETCH; ROM address is pc
- pc  out  PC_W  current program counter
- ir  out  16  latched instruction, drives decode, mux select and ALU controls
- a_reg  out  16  A register
- d_reg  out  16  D register
- write_req  out  1  RAM write request, held until mem_ack
- address_m  out  PC_W  RAM address. Equals a_reg[PC_W-1:0] except in WRITE, where it equals the latched write address.
- out_m  out  16  latched write data

## Operation
- FSM states: FETCH, EXEC, WRITE.
- Reset value of the FSM is FETCH. All registers reset to 0: pc, ir, a_reg, d_reg, the write latches, and write_req. fetch_req is 1 after reset.
- FETCH:
  - fetch_req=1.
  - On instr_valid=1: ir<=instr, next state EXEC.
  - Otherwise hold all state.
- EXEC (exactly one cycle), with c = ir[15]:
  - A load condition: !c | ir[5]. When true, a_reg<=a_mux_out.
  - D load condition: c & ir[4]. When true, d_reg<=alu_out.
  - Jump: jmp = c & ((ir[2]&ng) | (ir[1]&zr) | (ir[0]&!ng&!zr)).
  - pc <= jmp ? a_reg[PC_W-1:0] (the pre-update A) : pc+1, modulo 2^PC_W.
  - Write: if c & ir[3], latch wr_addr<=a_reg[PC_W-1:0] (pre-update A) and out_m<=alu_out, then go to WRITE. Otherwise go to FETCH.
- WRITE:
  - write_req=1. address_m and out_m are held stable.
  - On mem_ack=1: write_req<=0, next state FETCH.
- ALU inputs derive from a_reg/d_reg/inM and stay stable through EXEC. Latching out_m in EXEC isolates write data from the A update.
- Ignored inputs: instr_valid outside FETCH, mem_ack outside WRITE.

## Timing
- Minimum instruction period is 2 cycles (FETCH with instr_valid already high, then EXEC). Add 1 or more cycles when a write occurs: WRITE lasts until mem_ack, minimum 1 cycle when mem_ack is high on entry.
- New a_reg, d_reg and pc are visible the cycle after EXEC.
- write_req rises on the first WRITE cycle. It falls on the cycle after mem_ack is sampled high.
- PC wrap: pc=2^PC_W-1 with no jump -> pc=0.
- Same-instruction A load and M write (e.g. AM=D+1): the write uses the old A address, and A takes the new value.
- Same-instruction A load and jump: the jump targets the old A.
- rst_n low at any point, including mid-WRITE: outputs go to reset values immediately and asynchronously, and write_req drops without waiting for mem_ack. The FSM leaves reset in FETCH on the first clock edge after rst_n rises.

## Test plan
- Reset then A-instruction: rst_n low, release; instr=0x0005 with instr_valid=1 -> fetch_req=1 at pc=0; after EXEC, a_reg=0x0005, pc=1, write_req never high.
- C-instruction D=A: a_reg=5, instr=0xEC10, alu_out=5 -> d_reg=5, a_reg unchanged, pc+1, FSM back in FETCH after 1 EXEC cycle.
- Write with delayed ack: a_reg=0x0010, instr=M=D (0xE308), alu_out=0x1234, mem_ack after 3 cycles -> write_req high for exactly 3 cycles, address_m=0x0010, out_m=0x1234, pc+1 afterward.
- Jumps: a_reg=0x0100, instr=0;JLT (0xEA84) with ng=1 -> pc=0x0100. Same instruction with ng=0, zr=1 -> pc+1. instr=JMP (0xEA87) -> pc=0x0100 regardless of flags.
- AM=M+1 with a_reg=0x0020, a_mux_out=alu_out=0x0021 -> address_m=0x0020 during WRITE, a_reg=0x0021 after EXEC. PC wrap: pc=0x7FFF with no jump -> pc=0x0000.
- Reset during WRITE (before mem_ack): write_req, pc, a_reg and d_reg all 0 immediately; after release, fetch_req=1 and pc=0.

Source files
------------

// File: rtl/hack_state_unit_if.sv
// Memory-side handshake bundle of the Hack state unit: the instruction ROM
// fetch channel and the data RAM write channel.
interface hack_state_unit_if #(
    parameter int PC_W = 15
);
    // ROM fetch channel (the ROM address is the unit's program counter)
    logic            fetch_req;
    logic [15:0]     instr;
    logic            instr_valid;

    // RAM write channel
    logic            write_req;
    logic            mem_ack;
    logic [PC_W-1:0] address_m;
    logic [15:0]     out_m;

    // The CPU state unit drives requests and consumes ROM data / RAM acks
    modport master (
        output fetch_req,
        input  instr,
        input  instr_valid,
        output write_req,
        input  mem_ack,
        output address_m,
        output out_m
    );

    // The memory subsystem answers requests
    modport slave (
        input  fetch_req,
        output instr,
        output instr_valid,
        input  write_req,
        output mem_ack,
        input  address_m,
        input  out_m
    );
endinterface

// File: rtl/hack_state_unit.sv
// Hack CPU state-holding stage: A, D, PC and instruction registers, jump
// evaluation and a FETCH/EXEC/WRITE sequencer that handshakes with ROM and
// RAM so both may have variable latency.
module hack_state_unit #(
    parameter int PC_W = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    hack_state_unit_if.master mem,
    input  logic [15:0]      a_mux_out_i,
    input  logic [15:0]      alu_out_i,
    input  logic             zr_i,
    input  logic             ng_i,
    output logic [PC_W-1:0]  pc_o,
    output logic [15:0]      ir_o,
    output logic [15:0]      a_reg_o,
    output logic [15:0]      d_reg_o
);
    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]      state_q,     state_d;
    logic [PC_W-1:0] pc_q,        pc_d;
    logic [15:0]     ir_q,        ir_d;
    logic [15:0]     a_q,         a_d;
    logic [15:0]     d_q,         d_d;
    logic [PC_W-1:0] wr_addr_q,   wr_addr_d;
    logic [15:0]     out_m_q,     out_m_d;
    logic            write_req_q, write_req_d;

    // Instruction decode; a C-instruction has ir[15] set
    logic c_instr, a_load, d_load, m_write, jmp;
    logic [PC_W-1:0] a_addr;

    assign c_instr = ir_q[15];
    assign a_load  = !c_instr | ir_q[5];
    assign d_load  = c_instr & ir_q[4];
    assign m_write = c_instr & ir_q[3];
    assign jmp     = c_instr & ((ir_q[2] & ng_i) | (ir_q[1] & zr_i) |
                                (ir_q[0] & !ng_i & !zr_i));
    // Jump target and write address both use A as it was before this EXEC
    assign a_addr  = a_q[PC_W-1:0];

    // Next-state logic for the sequencer and all architectural registers
    always_comb begin
        // NOTE: every always_comb target gets a default first so no path leaves it unassigned and infers a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        a_d         = a_q;
        d_d         = d_q;
        wr_addr_d   = wr_addr_q;
        out_m_d     = out_m_q;
        write_req_d = write_req_q;
        case (state_q)
            S_FETCH: begin
                if (mem.instr_valid) begin
                    ir_d    = mem.instr;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (a_load) a_d = a_mux_out_i;
                if (d_load) d_d = alu_out_i;
                pc_d = jmp ? a_addr : pc_q + PC_W'(1);
                if (m_write) begin
                    // Latch the write so the A update cannot disturb it
                    wr_addr_d   = a_addr;
                    out_m_d     = alu_out_i;
                    write_req_d = 1'b1;
                    state_d     = S_WRITE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WRITE: begin
                if (mem.mem_ack) begin
                    write_req_d = 1'b0;
                    state_d     = S_FETCH;
                end
            end
            default: begin
                write_req_d = 1'b0;
                state_d     = S_FETCH;
            end
        endcase
    end

    // State registers with asynchronous reset to a clean FETCH at pc 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            d_q         <= '0;
            wr_addr_q   <= '0;
            out_m_q     <= '0;
            write_req_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            d_q         <= d_d;
            wr_addr_q   <= wr_addr_d;
            out_m_q     <= out_m_d;
            write_req_q <= write_req_d;
        end
    end

    // Memory handshake outputs; address_m switches to the latched address in WRITE
    assign mem.fetch_req = (state_q == S_FETCH);
    assign mem.write_req = write_req_q;
    assign mem.address_m = (state_q == S_WRITE) ? wr_addr_q : a_addr;
    assign mem.out_m     = out_m_q;

    assign pc_o    = pc_q;
    assign ir_o    = ir_q;
    assign a_reg_o = a_q;
    assign d_reg_o = d_q;
endmodule

// File: tb/tb_hack_state_unit.sv
// Self-checking bench for hack_state_unit: per-instruction expectations are
// queued when an instruction is presented and compared when it retires.
module tb_hack_state_unit;
    localparam int PC_W = 15;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [15:0]     a_mux_out = '0;
    logic [15:0]     alu_out = '0;
    logic            zr = 1'b0;
    logic            ng = 1'b0;
    logic [PC_W-1:0] pc_o;
    logic [15:0]     ir_o, a_reg_o, d_reg_o;

    always #5 clk = ~clk;

    hack_state_unit_if #(.PC_W(PC_W)) mem ();

    hack_state_unit #(.PC_W(PC_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem         (mem),
        .a_mux_out_i (a_mux_out),
        .alu_out_i   (alu_out),
        .zr_i        (zr),
        .ng_i        (ng),
        .pc_o        (pc_o),
        .ir_o        (ir_o),
        .a_reg_o     (a_reg_o),
        .d_reg_o     (d_reg_o)
    );

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [15:0]     a;
        logic [15:0]     d;
    } exp_t;

    typedef struct packed {
        logic [PC_W-1:0] addr;
        logic [15:0]     data;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];

    int tests_run = 0;
    int tests_failed = 0;

    // Bench-side architectural state of the last retired instruction
    logic [PC_W-1:0] m_pc = '0;
    logic [15:0]     m_a = '0;
    logic [15:0]     m_d = '0;

    // Present one instruction, run it to retirement and compare the result
    task automatic exec_instr(input logic [15:0] ins, input logic [15:0] amux,
                              input logic [15:0] alu, input logic z, input logic n,
                              input logic [PC_W-1:0] e_pc, input logic [15:0] e_a,
                              input logic [15:0] e_d, input bit do_wr,
                              input logic [15:0] w_data, input int ack_cycles);
        exp_t e;
        wr_t  w;
        int   waitc;
        int   hi;
        exp_q.push_back('{pc: e_pc, a: e_a, d: e_d});
        if (do_wr) wr_q.push_back('{addr: m_a[PC_W-1:0], data: w_data});

        waitc = 0;
        while (mem.fetch_req !== 1'b1 && waitc < 10) begin
            @(posedge clk); #1;
            waitc++;
        end
        tests_run++;
        if (mem.fetch_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL fetch_wait ins=%h: fetch_req=%b required 1", ins, mem.fetch_req);
        end
        tests_run++;
        if (pc_o !== m_pc) begin
            tests_failed++;
            $display("FAIL fetch_pc ins=%h: pc=%h required %h", ins, pc_o, m_pc);
        end

        mem.instr       = ins;
        mem.instr_valid = 1'b1;
        a_mux_out       = amux;
        alu_out         = alu;
        zr              = z;
        ng              = n;
        @(posedge clk); #1;
        // Junk on the ROM bus during EXEC must be ignored
        mem.instr_valid = 1'b1;
        mem.instr       = 16'hFFFF;
        tests_run++;
        if (ir_o !== ins || mem.fetch_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL exec_entry: ir=%h fetch_req=%b required ir=%h fetch_req=0",
                     ir_o, mem.fetch_req, ins);
        end

        @(posedge clk); #1;
        mem.instr_valid = 1'b0;
        if (do_wr) begin
            w  = wr_q.pop_front();
            hi = 0;
            while (mem.write_req === 1'b1 && hi < 20) begin
                hi++;
                tests_run++;
                if (mem.address_m !== w.addr || mem.out_m !== w.data) begin
                    tests_failed++;
                    $display("FAIL write_bus cycle %0d: addr=%h data=%h required addr=%h data=%h",
                             hi, mem.address_m, mem.out_m, w.addr, w.data);
                end
                if (hi >= ack_cycles) mem.mem_ack = 1'b1;
                @(posedge clk); #1;
                mem.mem_ack = 1'b0;
            end
            tests_run++;
            if (hi != ack_cycles) begin
                tests_failed++;
                $display("FAIL write_req_len ins=%h: high %0d cycles required %0d",
                         ins, hi, ack_cycles);
            end
        end else begin
            // An ack outside WRITE must not matter
            mem.mem_ack = 1'b1;
            tests_run++;
            if (mem.write_req !== 1'b0) begin
                tests_failed++;
                $display("FAIL no_write ins=%h: write_req=%b required 0", ins, mem.write_req);
            end
        end

        tests_run++;
        if (mem.fetch_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL back_to_fetch ins=%h: fetch_req=%b required 1", ins, mem.fetch_req);
        end
        e = exp_q.pop_front();
        tests_run++;
        if (pc_o !== e.pc || a_reg_o !== e.a || d_reg_o !== e.d) begin
            tests_failed++;
            $display("FAIL retire ins=%h: pc=%h a=%h d=%h required pc=%h a=%h d=%h",
                     ins, pc_o, a_reg_o, d_reg_o, e.pc, e.a, e.d);
        end
        @(negedge clk);
        mem.mem_ack = 1'b0;
        m_pc = e_pc;
        m_a  = e_a;
        m_d  = e_d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (pc_o !== '0 || ir_o !== '0 || a_reg_o !== '0 || d_reg_o !== '0 ||
            mem.write_req !== 1'b0 || mem.fetch_req !== 1'b1 || mem.out_m !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: pc=%h ir=%h a=%h d=%h wr=%b fr=%b om=%h required zeros, fetch_req=1",
                     pc_o, ir_o, a_reg_o, d_reg_o, mem.write_req, mem.fetch_req, mem.out_m);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = '0; m_a = '0; m_d = '0;
    endtask

    // @0005
    task automatic test_a_instr();
        exec_instr(16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b0,
                   m_pc + 1'b1, 16'h0005, m_d, 1'b0, 16'h0, 0);
    endtask

    // D=A
    task automatic test_c_dest();
        exec_instr(16'hEC10, 16'h0005, 16'h0005, 1'b0, 1'b0,
                   m_pc + 1'b1, m_a, 16'h0005, 1'b0, 16'h0, 0);
    endtask

    // @0010 then M=D with the ack arriving on the third WRITE cycle
    task automatic test_write_delayed();
        exec_instr(16'h0010, 16'h0010, 16'h0000, 1'b0, 1'b0,
                   m_pc + 1'b1, 16'h0010, m_d, 1'b0, 16'h0, 0);
        exec_instr(16'hE308, 16'hBEEF, 16'h1234, 1'b0, 1'b0,
                   m_pc + 1'b1, m_a, m_d, 1'b1, 16'h1234, 3);
    endtask

    task automatic test_jumps();
        exec_instr(16'h0100, 16'h0100, 16'h0000, 1'b0, 1'b0,
                   m_pc + 1'b1, 16'h0100, m_d, 1'b0, 16'h0, 0);
        // 0;JLT taken on ng
        exec_instr(16'hEA84, 16'h0000, 16'h8000, 1'b0, 1'b1,
                   15'h0100, m_a, m_d, 1'b0, 16'h0, 0);
        // 0;JLT not taken on zr
        exec_instr(16'hEA84, 16'h0000, 16'h0000, 1'b1, 1'b0,
                   m_pc + 1'b1, m_a, m_d, 1'b0, 16'h0, 0);
        // 0;JMP regardless of flags
        exec_instr(16'hEA87, 16'h0000, 16'h0000, 1'b0, 1'b0,
                   15'h0100, m_a, m_d, 1'b0, 16'h0, 0);
        exec_instr(16'hEA87, 16'h0000, 16'h8000, 1'b0, 1'b1,
                   15'h0100, m_a, m_d, 1'b0, 16'h0, 0);
        // 0;JGT taken on positive, not taken on zero
        exec_instr(16'hEA81, 16'h0000, 16'h0001, 1'b0, 1'b0,
                   15'h0100, m_a, m_d, 1'b0, 16'h0, 0);
        exec_instr(16'hEA81, 16'h0000, 16'h0000, 1'b1, 1'b0,
                   m_pc + 1'b1, m_a, m_d, 1'b0, 16'h0, 0);
        // A=0;JMP with A=0x0040: target is the old A, A still loads
        exec_instr(16'h0040, 16'h0040, 16'h0000, 1'b0, 1'b0,
                   m_pc + 1'b1, 16'h0040, m_d, 1'b0, 16'h0, 0);
        exec_instr(16'hEAA7, 16'h0077, 16'h0077, 1'b0, 1'b0,
                   15'h0040, 16'h0077, m_d, 1'b0, 16'h0, 0);
    endtask

    // @0020 then AM=M+1: write uses old A, A takes the new value
    task automatic test_am_write();
        exec_instr(16'h0020, 16'h0020, 16'h0000, 1'b0, 1'b0,
                   m_pc + 1'b1, 16'h0020, m_d, 1'b0, 16'h0, 0);
        exec_instr(16'hFDE8, 16'h0021, 16'h0021, 1'b0, 1'b0,
                   m_pc + 1'b1, 16'h0021, m_d, 1'b1, 16'h0021, 1);
    endtask

    // Jump to the top address, then a plain instruction wraps pc to 0
    task automatic test_pc_wrap();
        exec_instr(16'h7FFF, 16'h7FFF, 16'h0000, 1'b0, 1'b0,
                   m_pc + 1'b1, 16'h7FFF, m_d, 1'b0, 16'h0, 0);
        exec_instr(16'hEA87, 16'h0000, 16'h0000, 1'b0, 1'b0,
                   15'h7FFF, m_a, m_d, 1'b0, 16'h0, 0);
        exec_instr(16'h0003, 16'h0003, 16'h0000, 1'b0, 1'b0,
                   15'h0000, 16'h0003, m_d, 1'b0, 16'h0, 0);
    endtask

    // M=D stuck in WRITE with no ack, then reset asserted mid-cycle
    task automatic test_reset_mid_write();
        int waitc;
        waitc = 0;
        while (mem.fetch_req !== 1'b1 && waitc < 10) begin
            @(posedge clk); #1;
            waitc++;
        end
        mem.instr       = 16'hE308;
        mem.instr_valid = 1'b1;
        alu_out         = 16'h5A5A;
        @(posedge clk); #1;
        mem.instr_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests_run++;
        if (mem.write_req !== 1'b1 || mem.out_m !== 16'h5A5A) begin
            tests_failed++;
            $display("FAIL stuck_write: write_req=%b out_m=%h required 1 / 5a5a",
                     mem.write_req, mem.out_m);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (mem.write_req !== 1'b0 || pc_o !== '0 || a_reg_o !== '0 || d_reg_o !== '0) begin
            tests_failed++;
            $display("FAIL async_reset: write_req=%b pc=%h a=%h d=%h required all 0",
                     mem.write_req, pc_o, a_reg_o, d_reg_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (mem.fetch_req !== 1'b1 || pc_o !== '0 || mem.write_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL after_reset: fetch_req=%b pc=%h write_req=%b required 1/0/0",
                     mem.fetch_req, pc_o, mem.write_req);
        end
        m_pc = '0; m_a = '0; m_d = '0;
        // Machine is usable again from pc 0
        exec_instr(16'h0009, 16'h0009, 16'h0000, 1'b0, 1'b0,
                   15'h0001, 16'h0009, 16'h0000, 1'b0, 16'h0, 0);
    endtask

    initial begin
        mem.instr       = '0;
        mem.instr_valid = 1'b0;
        mem.mem_ack     = 1'b0;
        test_reset();
        test_a_instr();
        test_c_dest();
        test_write_delayed();
        test_jumps();
        test_am_write();
        test_pc_wrap();
        test_reset_mid_write();
        tests_run++;
        if (exp_q.size() != 0 || wr_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d/%0d entries left required 0",
                     exp_q.size(), wr_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
